// File: rtl/lsu_ctrl.sv
// Load/store unit: drives one 64-bit data-memory transaction per request and returns the aligned/extended result.
// Optional misalignment trapping is enabled with `define LSU_MISALIGN_CHECK_EN.
module lsu_ctrl #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [RW-1:0] req_rd,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [DW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wstrb,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic [RW-1:0] resp_rd,
    output logic          resp_we,
    output logic          resp_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_next;

    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [2:0]    a_q;
    logic [DW-4:0] addr_hi_q;
    logic [RW-1:0] rd_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    wstrb_q;
    logic [DW-1:0] data_q;
    logic          mis_q;

    logic [2:0]    a_fix;
    logic          mis_in;
    logic [7:0]    wstrb_in;
    logic [DW-1:0] shifted;
    logic [DW-1:0] ext;

    // Offset rounded down to the access size's natural alignment.
    always_comb begin
        a_fix = req_addr[2:0];
        case (req_size)
            2'd0:    a_fix = req_addr[2:0];
            2'd1:    a_fix = {req_addr[2:1], 1'b0};
            2'd2:    a_fix = {req_addr[2], 2'b00};
            default: a_fix = 3'b000;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        mis_in = (a_fix != req_addr[2:0]);
`else
        mis_in = 1'b0;
`endif
        wstrb_in = 8'h00;
        if (req_we) begin
            case (req_size)
                2'd0:    wstrb_in = 8'h01 << a_fix;
                2'd1:    wstrb_in = 8'h03 << a_fix;
                2'd2:    wstrb_in = 8'h0F << a_fix;
                default: wstrb_in = 8'hFF;
            endcase
        end
    end

    always_comb begin
        shifted = mem_rdata >> {a_q, 3'b000};
        ext     = shifted;
        case (size_q)
            2'd0:    ext = {{(DW-8){~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ext = {{(DW-16){~uns_q & shifted[15]}}, shifted[15:0]};
            2'd2:    ext = {{(DW-32){~uns_q & shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        mem_valid     = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wstrb     = 8'h00;
        mem_wdata     = '0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_rd       = '0;
        resp_we       = 1'b0;
        resp_misalign = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = mis_in ? RESP : REQ;
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_hi_q, 3'b000};
                mem_we    = we_q;
                mem_wstrb = wstrb_q;
                mem_wdata = wdata_q;
                if (mem_ready) state_next = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_next = RESP;
            end
            RESP: begin
                resp_valid    = 1'b1;
                resp_data     = data_q;
                resp_rd       = rd_q;
                resp_we       = we_q;
                resp_misalign = mis_q;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so memory and writeback see stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            a_q       <= 3'd0;
            addr_hi_q <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 8'h00;
            data_q    <= '0;
            mis_q     <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            a_q       <= a_fix;
            addr_hi_q <= req_addr[DW-1:3];
            rd_q      <= req_rd;
            wdata_q   <= req_wdata << {a_fix, 3'b000};
            wstrb_q   <= wstrb_in;
            data_q    <= '0;
            mis_q     <= mis_in;
        end else if (state == WAIT && mem_rvalid) begin
            data_q <= ext;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the integer ALU.
- Takes the ALU result as the effective address, plus rs2 as store data, and runs a valid/ready transaction on the 64-bit data-memory port.
- Aligns, masks and sign-/zero-extends load data, then returns one response per request to writeback.
- Multi-cycle; the core stalls while req_ready is low.

Parameters:
- DW, 64, datapath/address width; only 64 is supported (8 byte lanes).
- RW, 5, destination-register tag width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory op presented by ALU stage
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU/LWU)
- req_addr  in  DW  effective address (ALU result)
- req_wdata  in  DW  store data (rs2), right-justified
- req_rd  in  RW  load destination tag
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  DW  req_addr with [2:0] cleared
- mem_we  out  1  write enable
- mem_wstrb  out  8  byte-lane strobes
- mem_wdata  out  DW  store data shifted to lane
- mem_rvalid  in  1  load data valid
- mem_rdata  in  DW  load data, full doubleword
- resp_valid  out  1  response valid
- resp_ready  in  1  writeback accepts response
- resp_data  out  DW  extended load data; 0 for stores and faults
- resp_rd  out  RW  tag of the completing request
- resp_we  out  1  echoes req_we of the completing request
- resp_misalign  out  1  request was misaligned; no memory access performed

Behaviour:
- Reset: rst_n low forces state IDLE asynchronously.
  - All outputs 0, except req_ready=1.
  - Any in-flight transaction is abandoned.
  - A late mem_rvalid after reset is ignored in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we, size, unsigned, addr[2:0], rd and the lane-shifted wdata/wstrb into registers.
  - If misaligned, go to RESP with misalign=1; otherwise go to REQ.
  - Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0.
- REQ:
  - mem_valid=1; mem_addr/we/wstrb/wdata come from registers and are stable while mem_valid && !mem_ready.
  - On mem_ready: a store goes to RESP; a load goes to WAIT.
- WAIT:
  - mem_valid=0.
  - On mem_rvalid, register the extracted data and go to RESP.
  - Extraction: shift mem_rdata right by 8*addr[2:0], truncate to size, then sign-extend (req_unsigned=0) or zero-extend.
- RESP:
  - resp_valid=1; outputs held stable until resp_ready.
  - On resp_ready, go to IDLE; req_ready is asserted the next cycle (no back-to-back bypass).
- Outside their states: mem_valid=0 outside REQ, resp_valid=0 outside RESP, req_ready=0 outside IDLE.
- Strobes: byte=8'b1<<a; half=8'b11<<a; word=8'hF<<a; dword=8'hFF, where a=addr[2:0].
  - Loads drive wstrb=0.
  - wdata = req_wdata << 8*a.
- Minimum latency:
  - Store: req accepted at edge 0, mem handshake at edge 1, resp_valid visible after edge 1.
  - Load: additionally waits at least one WAIT cycle for mem_rvalid.
- mem_rvalid outside WAIT is ignored.
- req_valid while not in IDLE is not sampled.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: misalignment is detected as above; the request skips memory and responds with resp_misalign=1, resp_data=0.
- Undefined: no check is made.
  - resp_misalign is tied 0.
  - Low address bits that violate alignment are cleared to the size's natural alignment before strobe, shift and extract.
  - Every request accesses memory.

Test Plan:
- Reset mid-load: assert rst_n=0 in WAIT, then mem_rvalid=1 after release -> state IDLE, req_ready=1, resp_valid stays 0.
- Load byte signed: addr=0x1003, mem_rdata=0x0000_0000_8000_0000 -> wstrb=0, mem_addr=0x1000, resp_data=0xFFFF_FFFF_FFFF_FF80.
  - Same with req_unsigned=1 -> resp_data=0x80.
- Store half: addr=0x2006, wdata=0xABCD -> mem_addr=0x2000, wstrb=8'hC0, mem_wdata=0xABCD_0000_0000_0000.
  - resp_valid one cycle after mem_ready, resp_data=0.
- Backpressure: hold mem_ready=0 for 3 cycles, then resp_ready=0 for 2 cycles -> mem_* and resp_* outputs unchanged across stalls; exactly one response.
- Misaligned word at addr=0x3002:
  - With LSU_MISALIGN_CHECK_EN -> no mem_valid, resp_misalign=1, resp_data=0.
  - Without it -> mem access at 0x3000, wstrb=8'h0F for a store.
- Load dword: addr=0x4000, mem_rdata=0x1122_3344_5566_7788 -> resp_data identical, resp_rd equals captured req_rd.
